// File: rtl/rv_isa_pkg.sv
// RV64IM encoding constants, format codes and range helper
// shared by the instruction encoder slice.
package rv_isa_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_ISH  = 3'd2,
        FMT_S    = 3'd3,
        FMT_SB   = 3'd4,
        FMT_U    = 3'd5,
        FMT_UJ   = 3'd6,
        FMT_RSVD = 3'd7
    } fmt_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    localparam logic [31:0] NOP = 32'h00000013;

    // True when v[31:lsb] are all copies of the sign bit.
    function automatic logic fits(logic [31:0] v, int unsigned lsb);
        logic [31:0] s;
        s = 32'($signed(v) >>> lsb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request / result handshake bundle for the instruction encoder.
// The master drives requests and accepts results.
interface instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_func3;
    logic [6:0]  in_func7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic [5:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [31:0] instr_count;
    logic [15:0] err_count;

    modport master (
        output in_valid, in_fmt, in_opcode, in_func3,
        output in_func7, in_rd, in_rs1, in_rs2,
        output in_imm, in_shamt, out_ready,
        input  in_ready, out_valid, out_instr, out_err,
        input  instr_count, err_count
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_func3,
        input  in_func7, in_rd, in_rs1, in_rs2,
        input  in_imm, in_shamt, out_ready,
        output in_ready, out_valid, out_instr, out_err,
        output instr_count, err_count
    );

endinterface

// File: rtl/instr_encoder_fifo2.sv
// Two-entry 33-bit synchronous FIFO with occupancy count
// and a registered not-full flag.
module enc_fifo2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [32:0] wr_data,
    input  logic        rd_en,
    output logic [32:0] rd_data,
    output logic        not_full,
    output logic [1:0]  count
);

    logic [32:0] mem [2];
    logic        wptr;
    logic        rptr;
    logic        push;
    logic        pop;
    logic [1:0]  cnt_nxt;

    assign push    = wr_en && not_full;
    assign pop     = rd_en && (count != 2'd0);
    assign cnt_nxt = count + {1'b0, push} - {1'b0, pop};
    assign rd_data = (count != 2'd0) ? mem[rptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            count    <= 2'd0;
            not_full <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= wr_data;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            count    <= cnt_nxt;
            not_full <= (cnt_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV64IM fields into 32-bit words, flags illegal
// requests, queues results and counts delivered words.
module instr_encoder
    import rv_isa_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    instr_encoder_if.slave  bus
);

    fmt_t        fmt;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] word;
    logic        err;
    logic        accept;
    logic        pop;
    logic        not_full;
    logic [1:0]  count;
    logic [32:0] head;

    assign fmt = fmt_t'(bus.in_fmt);
    assign imm = bus.in_imm;
    assign op  = bus.in_opcode;
    assign f3  = bus.in_func3;
    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;

    always_comb begin
        word = '0;
        err  = 1'b0;
        unique case (1'b1)
            fmt == FMT_R: begin
                word = {bus.in_func7, rs2, rs1, f3, rd, op};
            end
            fmt == FMT_I: begin
                word = {imm[11:0], rs1, f3, rd, op};
                err  = !fits(imm, 11);
            end
            fmt == FMT_ISH: begin
                word = {bus.in_func7[6:1], bus.in_shamt,
                        rs1, f3, rd, op};
                err  = (op == OP_IMM32) && bus.in_shamt[5];
            end
            fmt == FMT_S: begin
                word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                err  = !fits(imm, 11);
            end
            fmt == FMT_SB: begin
                word = {imm[12], imm[10:5], rs2, rs1, f3,
                        imm[4:1], imm[11], op};
                err  = !fits(imm, 12) || imm[0];
            end
            fmt == FMT_U: begin
                word = {imm[31:12], rd, op};
                err  = (imm[11:0] != 12'h0);
            end
            fmt == FMT_UJ: begin
                word = {imm[20], imm[10:1], imm[11],
                        imm[19:12], rd, op};
                err  = !fits(imm, 20) || imm[0];
            end
            default: begin
                err = 1'b1;
            end
        endcase
        // Illegal requests still occupy a slot, but carry no word.
        if (err) begin
            word = '0;
        end
    end

    assign accept = bus.in_valid && not_full;
    assign pop    = bus.out_valid && bus.out_ready;

    enc_fifo2 u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (accept),
        .wr_data  ({err, word}),
        .rd_en    (pop),
        .rd_data  (head),
        .not_full (not_full),
        .count    (count)
    );

    assign bus.in_ready  = not_full;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_err   = head[32];
    assign bus.out_instr = head[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.instr_count <= '0;
            bus.err_count   <= '0;
        end else if (pop) begin
            if (!head[32]) begin
                bus.instr_count <= bus.instr_count + 32'd1;
            end else if (bus.err_count != 16'hFFFF) begin
                bus.err_count <= bus.err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: field-level reference model,
// per-cycle scoreboard compare and literal encodings.
module tb_instr_encoder;
    import rv_isa_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [32:0] expq [$];
    logic [31:0] m_icnt = '0;
    logic [15:0] m_ecnt = '0;
    logic        prev_up = 1'b0;

    task automatic chk(string name, logic [32:0] act,
                       logic [32:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        tests++;
        fails++;
        $display("FAIL %s: timeout got 0 want 1", name);
    endtask

    // Reference built from field positions and signed ranges.
    function automatic logic [32:0] model(
        logic [31:0] f, logic [31:0] op, logic [31:0] f3,
        logic [31:0] f7, logic [31:0] rd, logic [31:0] rs1,
        logic [31:0] rs2, logic [31:0] imm, logic [31:0] sh);
        logic [31:0] w;
        logic        e;
        int          si;
        si = $signed(imm);
        e  = 1'b0;
        w  = '0;
        case (f)
            0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15)
                 | (f3 << 12) | (rd << 7) | op;
            1: begin
                e = (si < -2048) || (si > 2047);
                w = ((imm & 32'hFFF) << 20) | (rs1 << 15)
                  | (f3 << 12) | (rd << 7) | op;
            end
            2: begin
                e = (op == 32'h1B) && (sh >= 32);
                w = ((f7 >> 1) << 26) | (sh << 20)
                  | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            end
            3: begin
                e = (si < -2048) || (si > 2047);
                w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20)
                  | (rs1 << 15) | (f3 << 12)
                  | ((imm & 32'h1F) << 7) | op;
            end
            4: begin
                e = (si < -4096) || (si > 4095) || (si % 2 != 0);
                w = (((imm >> 12) & 1) << 31)
                  | (((imm >> 5) & 32'h3F) << 25)
                  | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                  | (((imm >> 1) & 32'hF) << 8)
                  | (((imm >> 11) & 1) << 7) | op;
            end
            5: begin
                e = (imm % 4096) != 0;
                w = (imm & 32'hFFFFF000) | (rd << 7) | op;
            end
            6: begin
                e = (si < -1048576) || (si > 1048575)
                  || (si % 2 != 0);
                w = (((imm >> 20) & 1) << 31)
                  | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20)
                  | (((imm >> 12) & 32'hFF) << 12)
                  | (rd << 7) | op;
            end
            default: e = 1'b1;
        endcase
        if (e) w = '0;
        return {e, w};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            m_icnt  = '0;
            m_ecnt  = '0;
            prev_up = 1'b0;
        end else begin
            chk("sb_valid", 33'(bus.out_valid),
                33'(expq.size() != 0));
            chk("sb_icnt", 33'(bus.instr_count), 33'(m_icnt));
            chk("sb_ecnt", 33'(bus.err_count), 33'(m_ecnt));
            if (prev_up)
                chk("sb_ready", 33'(bus.in_ready),
                    33'(expq.size() < 2));
            if (expq.size() != 0) begin
                chk("sb_head", {bus.out_err, bus.out_instr},
                    expq[0]);
                if (bus.out_ready) begin
                    if (expq[0][32]) begin
                        if (m_ecnt != 16'hFFFF) m_ecnt++;
                    end else begin
                        m_icnt++;
                    end
                    void'(expq.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready)
                expq.push_back(model(
                    32'(bus.in_fmt), 32'(bus.in_opcode),
                    32'(bus.in_func3), 32'(bus.in_func7),
                    32'(bus.in_rd), 32'(bus.in_rs1),
                    32'(bus.in_rs2), bus.in_imm,
                    32'(bus.in_shamt)));
            prev_up = 1'b1;
        end
    end

    task automatic drive(logic [2:0] f, logic [6:0] op,
                         logic [2:0] f3, logic [6:0] f7,
                         logic [4:0] rd, logic [4:0] rs1,
                         logic [4:0] rs2, logic [31:0] imm,
                         logic [5:0] sh);
        bus.in_fmt    = f;
        bus.in_opcode = op;
        bus.in_func3  = f3;
        bus.in_func7  = f7;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
        bus.in_shamt  = sh;
        bus.in_valid  = 1'b1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the accept.
    task automatic send(logic [2:0] f, logic [6:0] op,
                        logic [2:0] f3, logic [6:0] f7,
                        logic [4:0] rd, logic [4:0] rs1,
                        logic [4:0] rs2, logic [31:0] imm,
                        logic [5:0] sh);
        bit ok = 0;
        drive(f, op, f3, f7, rd, rs1, rs2, imm, sh);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) timeout("send");
    endtask

    task automatic expect_out(string name, logic [31:0] w,
                              logic e);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1;
                chk(name, {bus.out_err, bus.out_instr}, {e, w});
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) timeout(name);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
              32'd0, 6'd0);
        bus.in_valid  = 1'b0;
        #2;
        chk("rst_in_ready", 33'(bus.in_ready), 33'd0);
        chk("rst_out_valid", 33'(bus.out_valid), 33'd0);
        chk("rst_word", {bus.out_err, bus.out_instr}, 33'd0);
        chk("rst_icnt", 33'(bus.instr_count), 33'd0);
        chk("rst_ecnt", 33'(bus.err_count), 33'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("model_pin_i", model(1, 32'h13, 0, 0, 1, 0, 0, 5, 0),
            {1'b0, 32'h00500093});

        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
             32'd5, 6'd0);
        expect_out("addi", 32'h00500093, 1'b0);
        chk("icnt_1", 33'(bus.instr_count), 33'd1);

        send(FMT_R, OP_REG, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2,
             32'd0, 6'd0);
        expect_out("add", 32'h002081B3, 1'b0);
        send(FMT_S, OP_STORE, 3'd3, 7'd0, 5'd0, 5'd2, 5'd5,
             32'd8, 6'd0);
        expect_out("sd", 32'h00513423, 1'b0);
        send(FMT_UJ, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
             32'd2048, 6'd0);
        expect_out("jal", 32'h001000EF, 1'b0);
        send(FMT_ISH, OP_IMM, 3'd1, 7'd0, 5'd5, 5'd6, 5'd0,
             32'd0, 6'd32);
        expect_out("slli", 32'h02031293, 1'b0);
        send(FMT_SB, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2,
             32'hFFFFFFFC, 6'd0);
        expect_out("beq", 32'hFE208EE3, 1'b0);
        send(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
             32'h12345000, 6'd0);
        expect_out("lui", 32'h123452B7, 1'b0);
        chk("icnt_7", 33'(bus.instr_count), 33'd7);

        send(FMT_UJ, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
             32'd3, 6'd0);
        expect_out("jal_odd", 32'h0, 1'b1);
        chk("ecnt_1", 33'(bus.err_count), 33'd1);
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
             32'd2048, 6'd0);
        expect_out("i_range", 32'h0, 1'b1);
        send(FMT_ISH, OP_IMM32, 3'd1, 7'd0, 5'd1, 5'd1, 5'd0,
             32'd0, 6'd32);
        expect_out("slliw_32", 32'h0, 1'b1);
        send(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
             32'h12345001, 6'd0);
        expect_out("u_low", 32'h0, 1'b1);
        send(FMT_RSVD, OP_REG, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
             32'd0, 6'd0);
        expect_out("rsvd", 32'h0, 1'b1);
        chk("ecnt_5", 33'(bus.err_count), 33'd5);
        chk("icnt_hold", 33'(bus.instr_count), 33'd7);

        bus.out_ready = 1'b0;
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0,
             32'd1, 6'd0);
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0,
             32'd2, 6'd0);
        drive(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0,
              32'd3, 6'd0);
        @(negedge clk);
        chk("full_ready", 33'(bus.in_ready), 33'd0);
        repeat (2) begin
            @(negedge clk);
            chk("hold_a", {bus.out_err, bus.out_instr},
                {1'b0, 32'h00100113});
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("pop_a", {bus.out_err, bus.out_instr},
            {1'b0, 32'h00100113});
        chk("still_full", 33'(bus.in_ready), 33'd0);
        @(negedge clk);
        chk("pop_b", {bus.out_err, bus.out_instr},
            {1'b0, 32'h00200193});
        chk("reopen", 33'(bus.in_ready), 33'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pop_c", {bus.out_err, bus.out_instr},
            {1'b0, 32'h00300213});
        @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0,
             32'd6, 6'd0);
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0,
             32'd7, 6'd0);
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 33'(bus.out_valid), 33'd0);
        chk("ar_icnt", 33'(bus.instr_count), 33'd0);
        chk("ar_ecnt", 33'(bus.err_count), 33'd0);
        chk("ar_ready", 33'(bus.in_ready), 33'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("deassert_ready", 33'(bus.in_ready), 33'd0);
        @(posedge clk);
        #1;
        chk("first_edge_ready", 33'(bus.in_ready), 33'd1);
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale", 33'(bus.out_valid), 33'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
